framebuffer_writer: RTL and testbench
=====================================

# framebuffer_writer

Downstream sink of the raytracing controller. Accepts the controller's per-pixel result stream (valid, x, y, 16-bit value), buffers it in a small FIFO, and writes it into the framebuffer BRAM through a request/grant port shared with other masters. It tracks frame completion and, when double-buffering is compiled in, swaps front/back banks on the display's vsync so scan-out never shows a partially rendered frame.

## Interface
Parameters:
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, ≥2
- FB_WIDTH, SCREEN_WIDTH, pixels per row
- FB_HEIGHT, SCREEN_HEIGHT, rows per frame

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle pulse when an opFrame instruction executes
- pixel_valid  in  1  pixel strobe from controller; no backpressure exists
- pixel_x  in  ScreenX  column
- pixel_y  in  ScreenY  row
- pixel_value  in  16  RGB565 colour
- display_vsync  in  1  one-cycle pulse at start of display vertical blank
- wr_req  out  1  BRAM write request
- wr_gnt  in  1  arbiter grant; write commits in a cycle with wr_req && wr_gnt
- wr_addr  out  FbAddr  word address within bank
- wr_data  out  16  pixel value
- wr_bank  out  1  bank being written (back bank)
- display_bank  out  1  bank scanned out (front bank)
- frame_done  out  1  one-cycle pulse when a completed frame becomes visible
- busy  out  1  state != IDLE
- dropped  out  1  sticky: at least one pixel discarded this frame

## Operation
- States: IDLE, FILL, WAIT_SWAP.
- IDLE -> FILL on frame_start: FIFO flushed, written-pixel counter cleared, dropped cleared.
- frame_start in FILL or WAIT_SWAP: abort, same actions as above, stay/enter FILL, banks unchanged.
- Push: pixel_valid in FILL with x<FB_WIDTH, y<FB_HEIGHT, and FIFO not full (or a pop in the same cycle). Stored entry = {y*FB_WIDTH+x, value}; address computed at push.
- Discard (sets dropped): FIFO full with no pop, coordinate out of range, or state != FILL.
- wr_req = FIFO non-empty; wr_addr/wr_data = FIFO head. Pop and counter++ on wr_req && wr_gnt.
- Counter reaches FB_WIDTH*FB_HEIGHT -> WAIT_SWAP on the next cycle; wr_req low.
- WAIT_SWAP: on display_vsync, toggle display_bank and wr_bank, pulse frame_done, go IDLE. A vsync in the same cycle as the final grant is ignored; the next one is used.
- Duplicate coordinates are written twice and counted twice; completion is count-based.

## Timing
- Reset: state IDLE, FIFO empty, wr_req 0, wr_addr 0, wr_data 0, wr_bank 1, display_bank 0, frame_done 0, busy 0, dropped 0.
- Pixel pushed at cycle N -> wr_req high at N+1 at the earliest.
- Sustained throughput: one pixel per cycle with wr_gnt held high.
- wr_addr/wr_data stay stable while wr_req is high without a grant.
- frame_done is high in the cycle after the accepting vsync, coincident with the new display_bank value.
- rst mid-frame: all state returns to reset values in the following cycle; there are no partial writes.

## Configuration
- FB_DOUBLE_BUFFER_EN defined: behaviour as above.
- FB_DOUBLE_BUFFER_EN undefined: single bank. wr_bank and display_bank are tied 0. WAIT_SWAP does not exist; frame_done pulses the cycle after the final grant and the state goes to IDLE. display_vsync is ignored.

## Structure
- proctypes package additions: FbAddr typedef, width $clog2(SCREEN_WIDTH*SCREEN_HEIGHT); FB_PIXELS constant. ScreenX/ScreenY/SCREEN_* already live there.
- Sub-module pixel_fifo: synchronous FIFO, parameterised width/depth, with flush, full, and empty signals. The FSM, address multiply, and counter stay in the top level.

## Test plan
- 4x2 frame, gnt always 1, pixels (0,0)..(3,1) back-to-back -> 8 writes, addresses 0..7, data matches. Vsync then gives frame_done, display_bank=1, wr_bank=0.
- gnt held 0 while 9 pixels arrive with FIFO_DEPTH=8 -> 8 stored, 9th discarded, dropped=1; writes drain in order once gnt is raised.
- Pixel (FB_WIDTH, 0) -> no write, dropped=1, counter unchanged.
- frame_start after 3 of 8 pixels -> FIFO flushed, counter 0, banks unchanged; the next 8 pixels complete the frame.
- Vsync in the same cycle as the final grant -> no swap; the following vsync swaps. With the macro undefined: frame_done the cycle after the final grant, banks stay 0.
- rst asserted in WAIT_SWAP -> all outputs at reset values next cycle; a later vsync produces no frame_done.

Source files
------------

// File: rtl/framebuffer_writer_pkg.sv
// Shared framebuffer types: screen coordinates, framebuffer word address, FIFO entry and writer FSM states.
package framebuffer_writer_pkg;

  localparam int unsigned SCREEN_WIDTH  = 320;
  localparam int unsigned SCREEN_HEIGHT = 240;
  localparam int unsigned FB_PIXELS     = SCREEN_WIDTH * SCREEN_HEIGHT;

  typedef logic [$clog2(SCREEN_WIDTH)-1:0]  ScreenX;
  typedef logic [$clog2(SCREEN_HEIGHT)-1:0] ScreenY;
  typedef logic [$clog2(FB_PIXELS)-1:0]     FbAddr;
  typedef logic [15:0]                      Rgb565;

  typedef struct packed {
    FbAddr addr;
    Rgb565 data;
  } fb_entry_t;

  typedef enum logic [1:0] {
    FBW_IDLE,
    FBW_FILL,
    FBW_WAIT_SWAP
  } fbw_state_e;

  // Row-major word address of a pixel within one bank.
  function automatic FbAddr fb_linear_addr(input ScreenX x, input ScreenY y,
                                           input int unsigned width);
    return FbAddr'(y) * FbAddr'(width) + FbAddr'(x);
  endfunction

endpackage

// File: rtl/framebuffer_writer_if.sv
// Framebuffer BRAM write port shared through an arbiter (request/grant).
interface framebuffer_writer_if;
  import framebuffer_writer_pkg::*;

  logic  wr_req;
  logic  wr_gnt;
  FbAddr wr_addr;
  Rgb565 wr_data;
  logic  wr_bank;

  modport master (output wr_req, wr_addr, wr_data, wr_bank, input wr_gnt);
  modport slave  (input wr_req, wr_addr, wr_data, wr_bank, output wr_gnt);

endinterface

// File: rtl/framebuffer_writer_pixel_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally and reads as zero when empty.
module pixel_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel stream -> FIFO -> arbitrated framebuffer BRAM writer with frame completion tracking.
// Optional FB_DOUBLE_BUFFER_EN: front/back bank swap on display vsync after a completed frame.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FB_WIDTH   = SCREEN_WIDTH,
  parameter int unsigned FB_HEIGHT  = SCREEN_HEIGHT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        pixel_valid,
  input  ScreenX                      pixel_x,
  input  ScreenY                      pixel_y,
  input  Rgb565                       pixel_value,
  input  logic                        display_vsync,
  framebuffer_writer_if.master        fb,
  output logic                        display_bank,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        dropped
);

  localparam int unsigned FRAME_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS + 1);
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic WR_BANK_RST = 1'b1;
`else
  localparam logic WR_BANK_RST = 1'b0;
`endif

  fbw_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_dropped;
  logic             r_frame_done;
  logic             r_wr_bank;
  logic             r_display_bank;

  fb_entry_t w_entry;
  fb_entry_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_req;
  logic      w_pop;
  logic      w_last_grant;
  logic      w_in_range;
  logic      w_push;
  logic      w_discard;
  logic      w_flush;

  assign w_in_range   = (32'(pixel_x) < FB_WIDTH) && (32'(pixel_y) < FB_HEIGHT);
  assign w_req        = !w_empty && (r_state == FBW_FILL);
  assign w_pop        = w_req && fb.wr_gnt;
  assign w_last_grant = w_pop && (r_count == CNT_W'(FRAME_PIXELS - 1));

  // Pixels arriving on the completing grant would only be flushed, so they count as discarded.
  assign w_push    = pixel_valid && !frame_start && (r_state == FBW_FILL) && w_in_range &&
                     !w_last_grant && (!w_full || w_pop);
  assign w_discard = pixel_valid && !frame_start && !w_push;
  assign w_flush   = frame_start || w_last_grant;

  assign w_entry.addr = fb_linear_addr(pixel_x, pixel_y, FB_WIDTH);
  assign w_entry.data = pixel_value;

  pixel_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FBW_IDLE;
      r_count        <= '0;
      r_dropped      <= 1'b0;
      r_frame_done   <= 1'b0;
      r_wr_bank      <= WR_BANK_RST;
      r_display_bank <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (frame_start) begin
        r_state   <= FBW_FILL;
        r_count   <= '0;
        r_dropped <= 1'b0;
      end else begin
        if (w_discard) r_dropped <= 1'b1;
        if (w_pop)     r_count   <= r_count + 1'b1;
        unique case (r_state)
          FBW_FILL: begin
            if (w_last_grant) begin
`ifdef FB_DOUBLE_BUFFER_EN
              r_state <= FBW_WAIT_SWAP;
`else
              r_state      <= FBW_IDLE;
              r_frame_done <= 1'b1;
`endif
            end
          end
          // Only entered with double buffering; single-bank builds never reach this state.
          FBW_WAIT_SWAP: begin
            if (display_vsync) begin
`ifdef FB_DOUBLE_BUFFER_EN
              r_wr_bank      <= ~r_wr_bank;
              r_display_bank <= ~r_display_bank;
`endif
              r_frame_done <= 1'b1;
              r_state      <= FBW_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fb.wr_req     = w_req;
  assign fb.wr_addr    = w_head.addr;
  assign fb.wr_data    = w_head.data;
  assign fb.wr_bank    = r_wr_bank;
  assign display_bank  = r_display_bank;
  assign frame_done    = r_frame_done;
  assign busy          = (r_state != FBW_IDLE);
  assign dropped       = r_dropped;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer on a 4x2 frame with an 8-entry FIFO; adapts to FB_DOUBLE_BUFFER_EN.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif
  localparam logic WB_RST = DB;

  typedef struct {
    logic        fs;
    logic        pv;
    int          x;
    int          y;
    logic [15:0] val;
    logic        gnt;
    logic        vs;
    logic        e_req;
    int          e_addr;
    logic [15:0] e_data;
    logic        e_done;
    logic        e_busy;
    logic        e_dbank;
    logic        e_wbank;
    logic        e_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pixel_valid;
  ScreenX      pixel_x;
  ScreenY      pixel_y;
  logic [15:0] pixel_value;
  logic        display_vsync;
  logic        display_bank;
  logic        frame_done;
  logic        busy;
  logic        dropped;

  int total = 0;
  int bad   = 0;

  framebuffer_writer_if bus ();

  framebuffer_writer #(
    .FIFO_DEPTH (8),
    .FB_WIDTH   (4),
    .FB_HEIGHT  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_value   (pixel_value),
    .display_vsync (display_vsync),
    .fb            (bus),
    .display_bank  (display_bank),
    .frame_done    (frame_done),
    .busy          (busy),
    .dropped       (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [15:0] pv(input int k);
    return 16'hC000 | 16'(k * 257);
  endfunction

  function automatic vec_t mk(input logic fs, input logic pvl, input int x, input int y,
                              input logic [15:0] val, input logic gnt, input logic vs,
                              input logic req, input int addr, input logic [15:0] data,
                              input logic done, input logic bsy, input logic dbank,
                              input logic wbank, input logic drop);
    vec_t v;
    v.fs = fs; v.pv = pvl; v.x = x; v.y = y; v.val = val; v.gnt = gnt; v.vs = vs;
    v.e_req = req; v.e_addr = addr; v.e_data = data; v.e_done = done; v.e_busy = bsy;
    v.e_dbank = dbank; v.e_wbank = wbank; v.e_drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start   = 1'b0;
    pixel_valid   = 1'b0;
    pixel_x       = '0;
    pixel_y       = '0;
    pixel_value   = '0;
    display_vsync = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.wr_gnt = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_pixel(input int x, input int y, input logic [15:0] val);
    pixel_valid = 1'b1;
    pixel_x     = ScreenX'(x);
    pixel_y     = ScreenY'(y);
    pixel_value = val;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Entry: FILL with empty FIFO. Streams pixels 0..7 with grant held, checks completion timing.
  task automatic run_frame(input string tag, input logic vs_final, input logic exp_drop);
    bus.wr_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        chk({tag, " stream req"}, 32'(bus.wr_req), 32'd1);
        chk({tag, " stream addr"}, 32'(bus.wr_addr), 32'(k - 1));
      end
      drive_pixel(k % 4, k / 4, pv(k));
      tick();
    end
    chk({tag, " last req"}, 32'(bus.wr_req), 32'd1);
    chk({tag, " last addr"}, 32'(bus.wr_addr), 32'd7);
    chk({tag, " last data"}, 32'(bus.wr_data), 32'(pv(7)));
    chk({tag, " not yet done"}, 32'(busy), 32'd1);
    pixel_valid   = 1'b0;
    display_vsync = vs_final;
    tick();
    display_vsync = 1'b0;
    chk({tag, " complete req"}, 32'(bus.wr_req), 32'd0);
    chk({tag, " complete busy"}, 32'(busy), 32'(DB));
    chk({tag, " complete done"}, 32'(frame_done), 32'(!DB));
    chk({tag, " complete dropped"}, 32'(dropped), 32'(exp_drop));
  endtask

  vec_t tbl [15];

  initial begin
    // fs pv x y val gnt vs | req addr data done busy dbank wbank drop
    tbl[0]  = mk(0, 0, 0, 0, 16'h0,  1, 0,  0, 0, 16'h0,  0,  0, 0, WB_RST, 0);
    tbl[1]  = mk(1, 0, 0, 0, 16'h0,  1, 0,  0, 0, 16'h0,  0,  0, 0, WB_RST, 0);
    tbl[2]  = mk(0, 1, 0, 0, pv(0),  1, 0,  0, 0, 16'h0,  0,  1, 0, WB_RST, 0);
    tbl[3]  = mk(0, 1, 1, 0, pv(1),  1, 0,  1, 0, pv(0),  0,  1, 0, WB_RST, 0);
    tbl[4]  = mk(0, 1, 2, 0, pv(2),  1, 0,  1, 1, pv(1),  0,  1, 0, WB_RST, 0);
    tbl[5]  = mk(0, 1, 3, 0, pv(3),  1, 0,  1, 2, pv(2),  0,  1, 0, WB_RST, 0);
    tbl[6]  = mk(0, 1, 0, 1, pv(4),  1, 0,  1, 3, pv(3),  0,  1, 0, WB_RST, 0);
    tbl[7]  = mk(0, 1, 1, 1, pv(5),  1, 0,  1, 4, pv(4),  0,  1, 0, WB_RST, 0);
    tbl[8]  = mk(0, 1, 2, 1, pv(6),  1, 0,  1, 5, pv(5),  0,  1, 0, WB_RST, 0);
    tbl[9]  = mk(0, 1, 3, 1, pv(7),  1, 0,  1, 6, pv(6),  0,  1, 0, WB_RST, 0);
    tbl[10] = mk(0, 0, 0, 0, 16'h0,  1, 0,  1, 7, pv(7),  0,  1, 0, WB_RST, 0);
    tbl[11] = mk(0, 0, 0, 0, 16'h0,  1, 0,  0, 0, 16'h0, !DB, DB, 0, WB_RST, 0);
    tbl[12] = mk(0, 0, 0, 0, 16'h0,  1, 1,  0, 0, 16'h0,  0, DB, 0, WB_RST, 0);
    tbl[13] = mk(0, 0, 0, 0, 16'h0,  1, 0,  0, 0, 16'h0,  DB, 0, DB, 1'b0, 0);
    tbl[14] = mk(0, 0, 0, 0, 16'h0,  1, 0,  0, 0, 16'h0,  0,  0, DB, 1'b0, 0);

    // Basic 4x2 frame, grant always high.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d req", i), 32'(bus.wr_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req || i == 0) begin
        chk($sformatf("tbl%0d addr", i), 32'(bus.wr_addr), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d data", i), 32'(bus.wr_data), 32'(tbl[i].e_data));
      end
      chk($sformatf("tbl%0d done", i), 32'(frame_done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d dbank", i), 32'(display_bank), 32'(tbl[i].e_dbank));
      chk($sformatf("tbl%0d wbank", i), 32'(bus.wr_bank), 32'(tbl[i].e_wbank));
      chk($sformatf("tbl%0d dropped", i), 32'(dropped), 32'(tbl[i].e_drop));
      frame_start   = tbl[i].fs;
      pixel_valid   = tbl[i].pv;
      pixel_x       = ScreenX'(tbl[i].x);
      pixel_y       = ScreenY'(tbl[i].y);
      pixel_value   = tbl[i].val;
      bus.wr_gnt    = tbl[i].gnt;
      display_vsync = tbl[i].vs;
      tick();
    end
    idle_inputs();

    // FIFO overflow with grant held low, then in-order drain.
    do_reset();
    start_frame();
    for (int k = 0; k < 8; k++) begin
      drive_pixel(k % 4, k / 4, pv(k));
      tick();
    end
    chk("ovf before 9th dropped", 32'(dropped), 32'd0);
    drive_pixel(1, 0, 16'hDEAD);
    tick();
    pixel_valid = 1'b0;
    chk("ovf dropped", 32'(dropped), 32'd1);
    chk("ovf held req", 32'(bus.wr_req), 32'd1);
    tick();
    chk("ovf stable addr", 32'(bus.wr_addr), 32'd0);
    chk("ovf stable data", 32'(bus.wr_data), 32'(pv(0)));
    bus.wr_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf drain%0d addr", k), 32'(bus.wr_addr), 32'(k));
      chk($sformatf("ovf drain%0d data", k), 32'(bus.wr_data), 32'(pv(k)));
      tick();
    end
    chk("ovf done req", 32'(bus.wr_req), 32'd0);
    chk("ovf done busy", 32'(busy), 32'(DB));
    chk("ovf done pulse", 32'(frame_done), 32'(!DB));
    chk("ovf still dropped", 32'(dropped), 32'd1);

    // Out-of-range coordinates are discarded and not counted.
    do_reset();
    start_frame();
    drive_pixel(4, 0, 16'h1111);
    tick();
    drive_pixel(0, 2, 16'h2222);
    tick();
    pixel_valid = 1'b0;
    chk("oor req", 32'(bus.wr_req), 32'd0);
    chk("oor dropped", 32'(dropped), 32'd1);
    run_frame("oor", 1'b0, 1'b1);

    // Abort mid-frame with frame_start.
    do_reset();
    start_frame();
    drive_pixel(5, 1, 16'h3333);
    tick();
    bus.wr_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_pixel(k % 4, k / 4, pv(k));
      tick();
    end
    pixel_valid = 1'b0;
    chk("abort pre addr", 32'(bus.wr_addr), 32'd2);
    chk("abort pre dropped", 32'(dropped), 32'd1);
    bus.wr_gnt = 1'b0;
    start_frame();
    chk("abort flushed req", 32'(bus.wr_req), 32'd0);
    chk("abort busy", 32'(busy), 32'd1);
    chk("abort dropped cleared", 32'(dropped), 32'd0);
    chk("abort dbank", 32'(display_bank), 32'd0);
    chk("abort wbank", 32'(bus.wr_bank), 32'(WB_RST));
    run_frame("abort", 1'b0, 1'b0);

    // Vsync coincident with the final grant is not used for the swap.
    do_reset();
    start_frame();
    run_frame("vsfin", 1'b1, 1'b0);
    chk("vsfin dbank", 32'(display_bank), 32'd0);
    chk("vsfin wbank", 32'(bus.wr_bank), 32'(WB_RST));
    tick();
    tick();
    chk("vsfin wait done", 32'(frame_done), 32'd0);
    chk("vsfin wait busy", 32'(busy), 32'(DB));
    display_vsync = 1'b1;
    tick();
    display_vsync = 1'b0;
    chk("vsfin swap done", 32'(frame_done), 32'(DB));
    chk("vsfin swap dbank", 32'(display_bank), 32'(DB));
    chk("vsfin swap wbank", 32'(bus.wr_bank), 32'd0);
    chk("vsfin swap busy", 32'(busy), 32'd0);
    tick();
    chk("vsfin pulse end", 32'(frame_done), 32'd0);

    // Reset while waiting for the swap, then reset with pixels queued.
    do_reset();
    start_frame();
    run_frame("rstw", 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw busy", 32'(busy), 32'd0);
    chk("rstw req", 32'(bus.wr_req), 32'd0);
    chk("rstw done", 32'(frame_done), 32'd0);
    chk("rstw dbank", 32'(display_bank), 32'd0);
    chk("rstw wbank", 32'(bus.wr_bank), 32'(WB_RST));
    display_vsync = 1'b1;
    tick();
    display_vsync = 1'b0;
    chk("rstw vsync no done", 32'(frame_done), 32'd0);
    chk("rstw vsync dbank", 32'(display_bank), 32'd0);
    start_frame();
    bus.wr_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_pixel(k, 0, pv(k));
      tick();
    end
    pixel_valid = 1'b0;
    chk("rstq pre req", 32'(bus.wr_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstq req", 32'(bus.wr_req), 32'd0);
    chk("rstq addr", 32'(bus.wr_addr), 32'd0);
    chk("rstq data", 32'(bus.wr_data), 32'd0);
    chk("rstq busy", 32'(busy), 32'd0);
    bus.wr_gnt = 1'b1;
    tick();
    chk("rstq no write", 32'(bus.wr_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
